// File: rtl/program_counter.sv
// program_counter: instruction fetch address sequencer for the WRA core.
// Drives the fetch address every cycle; decoder strobes for the current
// instruction select the next address (start/halt, absolute jump and a
// nested zero-overhead hardware-loop stack).
module program_counter #(
   parameter int unsigned ADDR_W     = 10,
   parameter int unsigned LOOP_DEPTH = 4,
   parameter int unsigned LOOP_CNT_W = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic [ADDR_W-1:0]     start_addr,
   input  logic                  stall,
   input  logic                  jump_en,
   input  logic [ADDR_W-1:0]     jump_addr,
   input  logic                  loop_push,
   input  logic [LOOP_CNT_W-1:0] loop_cnt,
   input  logic [ADDR_W-1:0]     loop_end,
   input  logic                  halt,
   output logic [ADDR_W-1:0]     InstrMemAddr,
   output logic                  running,
   output logic                  done,
   output logic                  loop_err
);

   localparam int unsigned SP_W  = $clog2(LOOP_DEPTH + 1);
   localparam int unsigned IDX_W = (LOOP_DEPTH > 1) ? $clog2(LOOP_DEPTH) : 1;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   state_t                state;
   logic [ADDR_W-1:0]     pc;
   logic [SP_W-1:0]       sp;
   logic [ADDR_W-1:0]     stk_start  [LOOP_DEPTH];
   logic [ADDR_W-1:0]     stk_end    [LOOP_DEPTH];
   logic [LOOP_CNT_W-1:0] stk_remain [LOOP_DEPTH];

   logic [IDX_W-1:0]      top_idx;
   logic [IDX_W-1:0]      push_idx;
   logic                  stack_empty;
   logic                  stack_full;
   logic                  top_hit;
   logic                  push_ok;
   logic [ADDR_W-1:0]     pc_inc;
   logic [ADDR_W-1:0]     skip_addr;

   // The fetch address is the PC register itself: no input-to-output path.
   assign InstrMemAddr = pc;

   // Stack top lookup and next-address candidates for the current PC.
   always_comb begin
      stack_empty = (sp == '0);
      stack_full  = (sp == SP_W'(LOOP_DEPTH));
      top_idx     = '0;
      if (!stack_empty) begin
         top_idx = IDX_W'(sp - 1'b1);
      end
      push_idx  = IDX_W'(sp);
      pc_inc    = pc + 1'b1;
      skip_addr = loop_end + 1'b1;
      top_hit   = !stack_empty && (pc == stk_end[top_idx]);
      push_ok   = !stack_full && (loop_end > pc);
   end

   // Control FSM, PC, loop stack and registered status outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         pc       <= '0;
         sp       <= '0;
         running  <= 1'b0;
         done     <= 1'b0;
         loop_err <= 1'b0;
         for (int unsigned i = 0; i < LOOP_DEPTH; i++) begin
            stk_start[i]  <= '0;
            stk_end[i]    <= '0;
            stk_remain[i] <= '0;
         end
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  pc       <= start_addr;
                  sp       <= '0;
                  loop_err <= 1'b0;
                  running  <= 1'b1;
                  state    <= RUN;
               end
            end
            RUN: begin
               if (stall) begin
                  // hold everything; a pending halt/jump is seen again next cycle
               end else if (halt) begin
                  sp      <= '0;
                  running <= 1'b0;
                  done    <= 1'b1;
                  state   <= IDLE;
               end else if (jump_en) begin
                  pc <= jump_addr;
               end else if (loop_push) begin
                  if (loop_cnt == '0) begin
                     pc <= skip_addr;
                  end else if (push_ok) begin
                     stk_start[push_idx]  <= pc_inc;
                     stk_end[push_idx]    <= loop_end;
                     stk_remain[push_idx] <= loop_cnt;
                     sp                   <= sp + 1'b1;
                     pc                   <= pc_inc;
                  end else begin
                     loop_err <= 1'b1;
                     pc       <= pc_inc;
                  end
               end else if (top_hit) begin
                  if (stk_remain[top_idx] > LOOP_CNT_W'(1)) begin
                     stk_remain[top_idx] <= stk_remain[top_idx] - 1'b1;
                     pc                  <= stk_start[top_idx];
                  end else begin
                     sp <= sp - 1'b1;
                     pc <= pc_inc;
                  end
               end else begin
                  pc <= pc_inc;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_program_counter.sv
// tb_program_counter: directed scenarios plus randomized decoder strobes,
// checked against a queue-based reference model of the sequencer.
module tb_program_counter;

   localparam int AW    = 10;
   localparam int DEPTH = 4;
   localparam int CW    = 16;
   localparam int MASK  = (1 << AW) - 1;

   logic          clk;
   logic          rst_n;
   logic          start;
   logic [AW-1:0] start_addr;
   logic          stall;
   logic          jump_en;
   logic [AW-1:0] jump_addr;
   logic          loop_push;
   logic [CW-1:0] loop_cnt;
   logic [AW-1:0] loop_end;
   logic          halt;
   logic [AW-1:0] addr;
   logic          running;
   logic          done;
   logic          loop_err;

   int checks = 0;
   int errors = 0;

   typedef struct {
      int s;
      int e;
      int r;
   } ent_t;

   ent_t m_stk[$];
   int   m_pc;
   bit   m_run;
   bit   m_done;
   bit   m_err;

   program_counter #(
      .ADDR_W    (AW),
      .LOOP_DEPTH(DEPTH),
      .LOOP_CNT_W(CW)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .start_addr  (start_addr),
      .stall       (stall),
      .jump_en     (jump_en),
      .jump_addr   (jump_addr),
      .loop_push   (loop_push),
      .loop_cnt    (loop_cnt),
      .loop_end    (loop_end),
      .halt        (halt),
      .InstrMemAddr(addr),
      .running     (running),
      .done        (done),
      .loop_err    (loop_err)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog time limit reached checks=%0d errors=%0d", checks, errors);
      $fatal(1);
   end

   function automatic void model_reset();
      m_stk.delete();
      m_pc   = 0;
      m_run  = 0;
      m_done = 0;
      m_err  = 0;
   endfunction

   // One clock edge of the sequencer, from the current input values.
   function automatic void model_step();
      int top;
      m_done = 0;
      if (!m_run) begin
         if (start) begin
            m_pc = int'(start_addr);
            m_stk.delete();
            m_err = 0;
            m_run = 1;
         end
      end else if (!stall) begin
         top = m_stk.size() - 1;
         if (halt) begin
            m_run  = 0;
            m_done = 1;
            m_stk.delete();
         end else if (jump_en) begin
            m_pc = int'(jump_addr);
         end else if (loop_push) begin
            if (loop_cnt == 0) begin
               m_pc = (int'(loop_end) + 1) & MASK;
            end else if (m_stk.size() < DEPTH && int'(loop_end) > m_pc) begin
               m_stk.push_back('{(m_pc + 1) & MASK, int'(loop_end), int'(loop_cnt)});
               m_pc = (m_pc + 1) & MASK;
            end else begin
               m_err = 1;
               m_pc  = (m_pc + 1) & MASK;
            end
         end else if (top >= 0 && m_stk[top].e == m_pc) begin
            if (m_stk[top].r > 1) begin
               m_stk[top].r = m_stk[top].r - 1;
               m_pc = m_stk[top].s;
            end else begin
               void'(m_stk.pop_back());
               m_pc = (m_pc + 1) & MASK;
            end
         end else begin
            m_pc = (m_pc + 1) & MASK;
         end
      end
   endfunction

   task automatic clear_inputs();
      start      = 1'b0;
      start_addr = '0;
      stall      = 1'b0;
      jump_en    = 1'b0;
      jump_addr  = '0;
      loop_push  = 1'b0;
      loop_cnt   = '0;
      loop_end   = '0;
      halt       = 1'b0;
   endtask

   task automatic cycle();
      model_step();
      @(posedge clk);
      #1;
   endtask

   task automatic goto(input int a);
      clear_inputs();
      jump_en   = 1'b1;
      jump_addr = a[AW-1:0];
      cycle();
      clear_inputs();
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      clear_inputs();
      model_reset();
      #2;
      checks++; if (addr !== 10'h000) begin errors++; $display("FAIL reset_addr got %h exp %h", addr, 10'h000); end
      checks++; if (running !== 1'b0) begin errors++; $display("FAIL reset_running got %b exp 0", running); end
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", done); end
      checks++; if (loop_err !== 1'b0) begin errors++; $display("FAIL reset_loop_err got %b exp 0", loop_err); end
      #10;
      rst_n = 1'b1;
      cycle();
      checks++; if (addr !== 10'h000 || running !== 1'b0) begin errors++; $display("FAIL idle_after_reset addr %h running %b exp 000 0", addr, running); end
   endtask

   task automatic test_sequential();
      start      = 1'b1;
      start_addr = 10'h010;
      cycle();
      clear_inputs();
      checks++; if (running !== 1'b1) begin errors++; $display("FAIL start_running got %b exp 1", running); end
      for (int i = 0; i < 5; i++) begin
         checks++; if (addr !== 10'(16 + i)) begin errors++; $display("FAIL seq_addr[%0d] got %h exp %h", i, addr, 10'(16 + i)); end
         if (i < 4) cycle();
      end
   endtask

   task automatic test_jump();
      goto(12'h012);
      checks++; if (addr !== 10'h012) begin errors++; $display("FAIL jump_setup got %h exp 012", addr); end
      jump_en   = 1'b1;
      jump_addr = 10'h200;
      cycle();
      clear_inputs();
      checks++; if (addr !== 10'h200) begin errors++; $display("FAIL jump_200 got %h exp 200", addr); end
      jump_en   = 1'b1;
      jump_addr = 10'h20F;
      loop_push = 1'b1;
      loop_end  = 10'h210;
      loop_cnt  = 16'd2;
      cycle();
      clear_inputs();
      checks++; if (addr !== 10'h20F) begin errors++; $display("FAIL jump_over_push got %h exp 20f", addr); end
      cycle();
      cycle();
      checks++; if (addr !== 10'h211) begin errors++; $display("FAIL jump_push_ignored got %h exp 211", addr); end
   endtask

   task automatic test_stall();
      goto(12'h013);
      stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         cycle();
         checks++; if (addr !== 10'h013) begin errors++; $display("FAIL stall_hold[%0d] got %h exp 013", i, addr); end
      end
      stall = 1'b0;
      cycle();
      checks++; if (addr !== 10'h014) begin errors++; $display("FAIL stall_release got %h exp 014", addr); end
      stall     = 1'b1;
      jump_en   = 1'b1;
      jump_addr = 10'h300;
      cycle();
      checks++; if (addr !== 10'h014) begin errors++; $display("FAIL stall_over_jump got %h exp 014", addr); end
      stall = 1'b0;
      cycle();
      clear_inputs();
      checks++; if (addr !== 10'h300) begin errors++; $display("FAIL jump_after_stall got %h exp 300", addr); end
   endtask

   task automatic test_single_loop();
      logic [AW-1:0] exp_tr [7] = '{10'h021, 10'h022, 10'h021, 10'h022, 10'h021, 10'h022, 10'h023};
      goto(12'h020);
      loop_push = 1'b1;
      loop_end  = 10'h022;
      loop_cnt  = 16'd3;
      cycle();
      clear_inputs();
      for (int i = 0; i < 7; i++) begin
         checks++; if (addr !== exp_tr[i]) begin errors++; $display("FAIL loop_trace[%0d] got %h exp %h", i, addr, exp_tr[i]); end
         if (i < 6) cycle();
      end
      goto(12'h022);
      cycle();
      checks++; if (addr !== 10'h023) begin errors++; $display("FAIL loop_stack_empty got %h exp 023", addr); end
   endtask

   task automatic test_nested();
      logic [AW-1:0] exp_tr [16] = '{10'h030, 10'h031, 10'h032, 10'h033, 10'h032, 10'h033, 10'h034, 10'h035,
                                     10'h031, 10'h032, 10'h033, 10'h032, 10'h033, 10'h034, 10'h035, 10'h036};
      int inner = 0;
      goto(12'h030);
      for (int i = 0; i < 16; i++) begin
         checks++; if (addr !== exp_tr[i]) begin errors++; $display("FAIL nested_trace[%0d] got %h exp %h", i, addr, exp_tr[i]); end
         if (addr == 10'h032) inner++;
         loop_push = 1'b0;
         if (addr == 10'h030) begin
            loop_push = 1'b1; loop_end = 10'h035; loop_cnt = 16'd2;
         end else if (addr == 10'h031) begin
            loop_push = 1'b1; loop_end = 10'h033; loop_cnt = 16'd2;
         end
         if (i < 15) cycle();
      end
      clear_inputs();
      checks++; if (inner !== 4) begin errors++; $display("FAIL nested_inner_count got %0d exp 4", inner); end
      loop_push = 1'b1;
      loop_end  = 10'h040;
      loop_cnt  = '0;
      cycle();
      clear_inputs();
      checks++; if (addr !== 10'h041) begin errors++; $display("FAIL zero_count_skip got %h exp 041", addr); end
      checks++; if (loop_err !== 1'b0) begin errors++; $display("FAIL zero_count_err got %b exp 0", loop_err); end
   endtask

   task automatic test_overflow();
      goto(12'h100);
      for (int k = 0; k < 5; k++) begin
         loop_push = 1'b1;
         loop_end  = 10'(12'h1F0 - k);
         loop_cnt  = 16'd5;
         cycle();
         checks++; if (addr !== 10'(12'h101 + k)) begin errors++; $display("FAIL overflow_addr[%0d] got %h exp %h", k, addr, 10'(12'h101 + k)); end
         checks++; if (loop_err !== (k == 4)) begin errors++; $display("FAIL overflow_err[%0d] got %b exp %b", k, loop_err, k == 4); end
      end
      clear_inputs();
      cycle();
      cycle();
      checks++; if (loop_err !== 1'b1) begin errors++; $display("FAIL err_sticky got %b exp 1", loop_err); end
   endtask

   task automatic test_bad_end();
      halt = 1'b1;
      cycle();
      clear_inputs();
      start      = 1'b1;
      start_addr = 10'h060;
      cycle();
      clear_inputs();
      checks++; if (loop_err !== 1'b0 || addr !== 10'h060) begin errors++; $display("FAIL start_clears_err err %b addr %h exp 0 060", loop_err, addr); end
      loop_push = 1'b1;
      loop_end  = 10'h060;
      loop_cnt  = 16'd3;
      cycle();
      clear_inputs();
      checks++; if (loop_err !== 1'b1 || addr !== 10'h061) begin errors++; $display("FAIL end_eq_pc err %b addr %h exp 1 061", loop_err, addr); end
      halt = 1'b1;
      cycle();
      clear_inputs();
      start      = 1'b1;
      start_addr = 10'h065;
      cycle();
      clear_inputs();
      loop_push = 1'b1;
      loop_end  = 10'h010;
      loop_cnt  = 16'd2;
      cycle();
      clear_inputs();
      checks++; if (loop_err !== 1'b1 || addr !== 10'h066) begin errors++; $display("FAIL end_lt_pc err %b addr %h exp 1 066", loop_err, addr); end
   endtask

   task automatic test_halt();
      goto(12'h050);
      halt = 1'b1;
      cycle();
      clear_inputs();
      checks++; if (running !== 1'b0 || done !== 1'b1 || addr !== 10'h050) begin errors++; $display("FAIL halt_edge running %b done %b addr %h exp 0 1 050", running, done, addr); end
      cycle();
      checks++; if (running !== 1'b0 || done !== 1'b0 || addr !== 10'h050) begin errors++; $display("FAIL halt_after running %b done %b addr %h exp 0 0 050", running, done, addr); end
      jump_en   = 1'b1;
      jump_addr = 10'h123;
      loop_push = 1'b1;
      loop_end  = 10'h200;
      loop_cnt  = 16'd1;
      cycle();
      clear_inputs();
      checks++; if (addr !== 10'h050 || running !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL idle_ignores addr %h running %b done %b exp 050 0 0", addr, running, done); end
      start      = 1'b1;
      start_addr = 10'h070;
      cycle();
      clear_inputs();
      stall = 1'b1;
      halt  = 1'b1;
      cycle();
      checks++; if (running !== 1'b1 || done !== 1'b0 || addr !== 10'h070) begin errors++; $display("FAIL stall_over_halt running %b done %b addr %h exp 1 0 070", running, done, addr); end
      stall = 1'b0;
      cycle();
      clear_inputs();
      checks++; if (running !== 1'b0 || done !== 1'b1 || addr !== 10'h070) begin errors++; $display("FAIL halt_after_stall running %b done %b addr %h exp 0 1 070", running, done, addr); end
   endtask

   task automatic test_start_ignored();
      start      = 1'b1;
      start_addr = 10'h080;
      cycle();
      start_addr = 10'h3FF;
      cycle();
      clear_inputs();
      checks++; if (addr !== 10'h081 || running !== 1'b1) begin errors++; $display("FAIL start_in_run addr %h running %b exp 081 1", addr, running); end
      goto(12'h3FF);
      cycle();
      checks++; if (addr !== 10'h000) begin errors++; $display("FAIL pc_wrap got %h exp 000", addr); end
      goto(12'h3F0);
      loop_push = 1'b1;
      loop_end  = 10'h3FF;
      loop_cnt  = '0;
      cycle();
      clear_inputs();
      checks++; if (addr !== 10'h000) begin errors++; $display("FAIL skip_wrap got %h exp 000", addr); end
   endtask

   task automatic test_reset_mid_loop();
      goto(12'h090);
      loop_push = 1'b1;
      loop_end  = 10'h093;
      loop_cnt  = 16'd10;
      cycle();
      loop_end  = 10'h001;
      loop_cnt  = 16'd1;
      cycle();
      clear_inputs();
      checks++; if (loop_err !== 1'b1 || addr !== 10'h092) begin errors++; $display("FAIL pre_reset err %b addr %h exp 1 092", loop_err, addr); end
      #2;
      rst_n = 1'b0;
      model_reset();
      #1;
      checks++; if (addr !== 10'h000 || running !== 1'b0 || loop_err !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL async_reset addr %h running %b err %b done %b exp 000 0 0 0", addr, running, loop_err, done); end
      #3;
      rst_n = 1'b1;
      cycle();
      checks++; if (addr !== 10'h000 || running !== 1'b0) begin errors++; $display("FAIL post_reset_idle addr %h running %b exp 000 0", addr, running); end
      start      = 1'b1;
      start_addr = 10'h092;
      cycle();
      clear_inputs();
      cycle();
      cycle();
      checks++; if (addr !== 10'h094) begin errors++; $display("FAIL reset_empties_stack got %h exp 094", addr); end
   endtask

   task automatic test_random();
      int tmp;
      for (int n = 0; n < 500; n++) begin
         clear_inputs();
         start      = ($urandom_range(0, 3) == 0);
         start_addr = 10'($urandom_range(0, MASK));
         if (m_run) begin
            start     = ($urandom_range(0, 9) == 0);
            stall     = ($urandom_range(0, 9) == 0);
            halt      = ($urandom_range(0, 39) == 0);
            jump_en   = ($urandom_range(0, 14) == 0);
            jump_addr = 10'($urandom_range(0, MASK));
            loop_push = ($urandom_range(0, 4) == 0);
            tmp       = m_pc + int'($urandom_range(0, 7)) - 1;
            loop_end  = tmp[AW-1:0];
            loop_cnt  = 16'($urandom_range(0, 3));
         end
         cycle();
         checks++; if (addr !== 10'(m_pc)) begin errors++; $display("FAIL rand_addr[%0d] got %h exp %h", n, addr, 10'(m_pc)); end
         checks++; if (running !== m_run) begin errors++; $display("FAIL rand_running[%0d] got %b exp %b", n, running, m_run); end
         checks++; if (done !== m_done) begin errors++; $display("FAIL rand_done[%0d] got %b exp %b", n, done, m_done); end
         checks++; if (loop_err !== m_err) begin errors++; $display("FAIL rand_loop_err[%0d] got %b exp %b", n, loop_err, m_err); end
      end
      clear_inputs();
   endtask

   initial begin
      test_reset();
      test_sequential();
      test_jump();
      test_stall();
      test_single_loop();
      test_nested();
      test_overflow();
      test_bad_end();
      test_halt();
      test_start_ignored();
      test_reset_mid_loop();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
